// File: rtl/dram_req_ctrl.sv
// Request front end for a simple DRAM PHY: single-cycle read/write issue,
// in-order read responses tagged from a small FIFO, plus status counters.
module dram_req_ctrl #(
    parameter int RAM_ADDR   = 22,
    parameter int RAM_DWIDTH = 32,
    parameter int TAG_W      = 4,
    parameter int MAX_OUTST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [RAM_ADDR-1:0]   req_addr,
    input  logic [RAM_DWIDTH-1:0] req_data,
    input  logic [TAG_W-1:0]      req_tag,
    output logic                  resp_valid,
    output logic [RAM_DWIDTH-1:0] resp_data,
    output logic [TAG_W-1:0]      resp_tag,
    output logic                  phy_wr_en,
    output logic [RAM_DWIDTH-1:0] phy_wr_din,
    output logic [RAM_ADDR-1:0]   phy_addr,
    output logic                  phy_rd_en,
    input  logic [RAM_DWIDTH-1:0] phy_rd_dout,
    input  logic                  phy_rd_valid,
    output logic                  busy,
    output logic                  err,
    output logic [31:0]           wr_cnt,
    output logic [31:0]           rd_cnt
);

    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(MAX_OUTST);

    logic [TAG_W-1:0] tag_mem [MAX_OUTST];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             accept;
    logic             wr_acc;
    logic             rd_acc;
    logic             pop;
    logic             spurious;
    logic [TAG_W-1:0] head_tag;

    assign accept   = req_valid & req_ready;
    assign wr_acc   = accept & req_write;
    assign rd_acc   = accept & ~req_write;
    // A read pushed while the FIFO is empty can be popped in the same cycle;
    // its tag then bypasses the storage array.
    assign pop      = phy_rd_valid & ((count != '0) | rd_acc);
    assign spurious = phy_rd_valid & (count == '0) & ~rd_acc;
    assign head_tag = (count == '0) ? req_tag : tag_mem[rd_ptr];
    assign busy     = (count != '0);

    always_comb begin
        count_next = count;
        case ({rd_acc, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rd_acc)
            tag_mem[wr_ptr] <= req_tag;
    end

    // req_ready is registered from the next count so it never depends on req_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            req_ready  <= 1'b0;
            phy_wr_en  <= 1'b0;
            phy_rd_en  <= 1'b0;
            phy_addr   <= '0;
            phy_wr_din <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_tag   <= '0;
            err        <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
        end else begin
            count      <= count_next;
            req_ready  <= (count_next != FULL);
            phy_wr_en  <= wr_acc;
            phy_rd_en  <= rd_acc;
            resp_valid <= pop;
            if (accept)
                phy_addr <= req_addr;
            if (wr_acc) begin
                phy_wr_din <= req_data;
                wr_cnt     <= wr_cnt + 32'd1;
            end
            if (rd_acc)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + PW'(1);
                resp_data <= phy_rd_dout;
                resp_tag  <= head_tag;
                rd_cnt    <= rd_cnt + 32'd1;
            end
            if (spurious)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dram_req_ctrl.sv
// Self-checking bench for dram_req_ctrl: directed scenarios plus random traffic
// compared against a queue-based transaction model.
module tb_dram_req_ctrl;

    localparam int AW = 22;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [TW-1:0] req_tag;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic [TW-1:0] resp_tag;
    logic          phy_wr_en;
    logic [DW-1:0] phy_wr_din;
    logic [AW-1:0] phy_addr;
    logic          phy_rd_en;
    logic [DW-1:0] phy_rd_dout;
    logic          phy_rd_valid;
    logic          busy;
    logic          err;
    logic [31:0]   wr_cnt;
    logic [31:0]   rd_cnt;

    always #5 clk = ~clk;

    dram_req_ctrl #(.RAM_ADDR(AW), .RAM_DWIDTH(DW), .TAG_W(TW), .MAX_OUTST(MO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag),
        .phy_wr_en(phy_wr_en), .phy_wr_din(phy_wr_din), .phy_addr(phy_addr),
        .phy_rd_en(phy_rd_en), .phy_rd_dout(phy_rd_dout), .phy_rd_valid(phy_rd_valid),
        .busy(busy), .err(err), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    int total = 0;
    int bad = 0;

    // Transaction-level model: outstanding reads are a tag queue.
    logic [TW-1:0] tag_q[$];
    bit            m_ready, m_wr_en, m_rd_en, m_resp_valid, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din, m_rdata;
    logic [TW-1:0] m_rtag;
    logic [31:0]   m_wr_cnt, m_rd_cnt;
    logic [DW-1:0] mem [0:15];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        tag_q.delete();
        m_ready = 0; m_wr_en = 0; m_rd_en = 0; m_resp_valid = 0; m_err = 0;
        m_addr = '0; m_din = '0; m_rdata = '0; m_rtag = '0;
        m_wr_cnt = '0; m_rd_cnt = '0;
    endtask

    task automatic modelClock();
        bit acc;
        acc = req_valid && m_ready;
        m_wr_en = acc && req_write;
        m_rd_en = acc && !req_write;
        if (acc) m_addr = req_addr;
        if (m_wr_en) begin
            m_din = req_data;
            m_wr_cnt = m_wr_cnt + 1;
            if (req_addr < 16) mem[req_addr[3:0]] = req_data;
        end
        if (m_rd_en) tag_q.push_back(req_tag);
        m_resp_valid = 0;
        if (phy_rd_valid) begin
            if (tag_q.size() > 0) begin
                m_rtag = tag_q.pop_front();
                m_rdata = phy_rd_dout;
                m_resp_valid = 1;
                m_rd_cnt = m_rd_cnt + 1;
            end else begin
                m_err = 1;
            end
        end
        m_ready = tag_q.size() < MO;
    endtask

    task automatic checkAll();
        checkOutput("ready", req_ready, m_ready);
        checkOutput("wr_en", phy_wr_en, m_wr_en);
        checkOutput("rd_en", phy_rd_en, m_rd_en);
        checkOutput("excl", phy_wr_en & phy_rd_en, 0);
        checkOutput("addr", phy_addr, m_addr);
        checkOutput("din", phy_wr_din, m_din);
        checkOutput("resp_valid", resp_valid, m_resp_valid);
        checkOutput("resp_data", resp_data, m_rdata);
        checkOutput("resp_tag", resp_tag, m_rtag);
        checkOutput("busy", busy, tag_q.size() != 0);
        checkOutput("err", err, m_err);
        checkOutput("wr_cnt", wr_cnt, m_wr_cnt);
        checkOutput("rd_cnt", rd_cnt, m_rd_cnt);
    endtask

    // Drive one cycle of inputs at the falling edge, advance one rising edge, check.
    task automatic applyStimulus(input bit v, input bit w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [TW-1:0] t,
                                 input bit rv, input logic [DW-1:0] rd);
        req_valid = v; req_write = w; req_addr = a; req_data = d; req_tag = t;
        phy_rd_valid = rv; phy_rd_dout = rd;
        @(posedge clk);
        modelClock();
        @(negedge clk);
        checkAll();
    endtask

    task automatic idle();
        applyStimulus(0, 0, '0, '0, '0, 0, '0);
    endtask

    initial begin
        logic [DW-1:0] wdata [0:2];
        wdata[0] = 32'h11223344; wdata[1] = 32'hABCDEF12; wdata[2] = 32'h01234567;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst = 1'b1;
        req_valid = 0; req_write = 0; req_addr = '0; req_data = '0; req_tag = '0;
        phy_rd_valid = 0; phy_rd_dout = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkAll();
        rst = 1'b0;
        idle();
        checkOutput("ready_after_rst", req_ready, 1);

        // Three back-to-back writes, then three tagged reads, then their data.
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 1, AW'(i + 1), wdata[i], '0, 0, '0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 0, AW'(i + 1), '0, TW'(i + 1), 0, '0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, '0, '0, '0, 1, mem[i + 1]);
            checkOutput("seq_valid", resp_valid, 1);
            checkOutput("seq_data", resp_data, wdata[i]);
            checkOutput("seq_tag", resp_tag, i + 1);
        end
        idle();
        checkOutput("seq_wr_cnt", wr_cnt, 3);
        checkOutput("seq_rd_cnt", rd_cnt, 3);
        checkOutput("seq_err", err, 0);

        // Fill the tag FIFO, then free one slot.
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 0, AW'(i), '0, TW'(8 + i), 0, '0);
        checkOutput("full_ready", req_ready, 0);
        checkOutput("full_busy", busy, 1);
        applyStimulus(1, 0, AW'(9), '0, TW'(15), 0, '0);
        checkOutput("full_no_issue", phy_rd_en, 0);
        applyStimulus(0, 0, '0, '0, '0, 1, 32'hCAFE0000);
        checkOutput("full_ready_back", req_ready, 1);
        checkOutput("full_tag", resp_tag, 8);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, '0, '0, '0, 1, 32'hCAFE0001 + i);
        idle();
        checkOutput("drained_busy", busy, 0);

        // Simultaneous push and pop with one outstanding read.
        applyStimulus(1, 0, AW'(4), '0, TW'(5), 0, '0);
        applyStimulus(1, 0, AW'(5), '0, TW'(6), 1, 32'h55555555);
        checkOutput("pp_tag", resp_tag, 5);
        checkOutput("pp_busy", busy, 1);
        applyStimulus(0, 0, '0, '0, '0, 1, 32'h66666666);
        checkOutput("pp_tag2", resp_tag, 6);
        idle();
        checkOutput("pp_busy0", busy, 0);

        // Spurious read data sets a sticky error.
        applyStimulus(0, 0, '0, '0, '0, 1, 32'hDEADBEEF);
        checkOutput("spur_err", err, 1);
        checkOutput("spur_resp", resp_valid, 0);
        repeat (10) idle();
        checkOutput("spur_sticky", err, 1);

        // Asynchronous reset between edges with reads in flight.
        applyStimulus(1, 0, AW'(7), '0, TW'(1), 0, '0);
        applyStimulus(1, 0, AW'(8), '0, TW'(2), 0, '0);
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        checkOutput("arst_rd_en", phy_rd_en, 0);
        @(negedge clk);
        checkAll();
        rst = 1'b0;
        idle();
        applyStimulus(0, 0, '0, '0, '0, 1, 32'h12345678);
        checkOutput("late_err", err, 1);
        checkOutput("late_resp", resp_valid, 0);

        // Write counter wrap from a preloaded all-ones value.
        force dut.wr_cnt = 32'hFFFFFFFF;
        m_wr_cnt = 32'hFFFFFFFF;
        idle();
        release dut.wr_cnt;
        checkOutput("wrap_pre", wr_cnt, 32'hFFFFFFFF);
        applyStimulus(1, 1, AW'(3), 32'h0BADF00D, '0, 0, '0);
        checkOutput("wrap_zero", wr_cnt, 0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bit rv;
            rv = (tag_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom),
                          $urandom, TW'($urandom), rv, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("[TB] FAIL timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] timeout");
    end

endmodule
